fdt_tx_scheduler: RTL

//  Sequences the PICC reply after a PCD frame. Measures the frame delay time from the last

---
 rtl/fdt_pkg.sv | 29 ++
 rtl/fdt_slot_counter.sv | 75 +++++++
 rtl/fdt_tx_scheduler.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/fdt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fdt_pkg
// Description : Shared types and constants for the PICC reply scheduler.
//               State encoding, nominal frame-delay-time targets (in clk ticks
//               from the last pause rise) and the late-slot grid period.
// Revision    : 1.0 - initial release
// ============================================================================
package fdt_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_FDT = 3'd1,
        LATE     = 3'd2,
        TX       = 3'd3,
        DROP     = 3'd4
    } fdt_state_t;

    // Nominal FDT from the last pause rise, selected by the final rx data bit.
    localparam int FDT_LAST_BIT_0 = 1172;
    localparam int FDT_LAST_BIT_1 = 1236;
    // Spacing of the reply grid after the nominal point.
    localparam int FDT_SLOT_TICKS = 128;
    // Slot register width: one bit wider than slot_idx so slot 8 is representable
    // as the point where the last late slot's window closes.
    localparam int SLOT_W = 4;

endpackage
`default_nettype wire

// File: rtl/fdt_slot_counter.sv
`default_nettype none
// ============================================================================
// Module      : fdt_slot_counter
// Description : Delay counter, FDT target latch and reply-slot register.
//               match is high while the counter equals base + 128*slot.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               cnt_clear       - restart the counter at 0 (pause rise)
//               cnt_hold        - freeze the counter (reply in flight)
//               target_load     - latch base target from last_rx_bit
//               last_rx_bit     - final data bit of the PCD frame
//               slot_clear      - return to slot 0
//               slot_inc        - advance to the next 128-tick slot
//               match           - counter equals the active target
//               slot            - current slot number
// Revision    : 1.0 - initial release
// ============================================================================
module fdt_slot_counter
    import fdt_pkg::*;
#(
    parameter int TIMING_ADJUST = 6,
    parameter int CNT_WIDTH     = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cnt_clear,
    input  logic              cnt_hold,
    input  logic              target_load,
    input  logic              last_rx_bit,
    input  logic              slot_clear,
    input  logic              slot_inc,
    output logic              match,
    output logic [SLOT_W-1:0] slot
);

    localparam logic [CNT_WIDTH-1:0] c_base_0 = CNT_WIDTH'(FDT_LAST_BIT_0 - TIMING_ADJUST);
    localparam logic [CNT_WIDTH-1:0] c_base_1 = CNT_WIDTH'(FDT_LAST_BIT_1 - TIMING_ADJUST);
    localparam logic [CNT_WIDTH-1:0] c_slot_ticks = CNT_WIDTH'(FDT_SLOT_TICKS);

    logic [CNT_WIDTH-1:0] r_count;
    logic [CNT_WIDTH-1:0] r_base;
    logic [SLOT_W-1:0]    r_slot;
    logic [CNT_WIDTH-1:0] w_target;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_base  <= '0;
            r_slot  <= '0;
        end else begin
            // Saturating: a long silence must never alias back onto a target.
            if (cnt_clear) begin
                r_count <= '0;
            end else if (!cnt_hold && (r_count != '1)) begin
                r_count <= r_count + 1'b1;
            end

            if (target_load) begin
                r_base <= last_rx_bit ? c_base_1 : c_base_0;
            end

            if (slot_clear) begin
                r_slot <= '0;
            end else if (slot_inc) begin
                r_slot <= r_slot + 1'b1;
            end
        end
    end

    // Constant power-of-two multiply reduces to a shift.
    assign w_target = r_base + (CNT_WIDTH'(r_slot) * c_slot_ticks);
    assign match    = (r_count == w_target);
    assign slot     = r_slot;

endmodule
`default_nettype wire

// File: rtl/fdt_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fdt_tx_scheduler
// Description : Releases the PICC reply on the FDT grid after a PCD frame.
//               The delay counter restarts on each pause rise; tx_go fires on
//               an exact match with the latched target. A missed nominal point
//               either moves to later 128-tick slots or drops the reply.
// Config      : `FDT_LATE_SLOT_EN - enables the LATE state and slots
//               1..MAX_LATE_SLOTS; otherwise a miss drops and slot_idx is 0.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               pause_n_synchronised - synchronised PCD pause (active low)
//               last_rx_bit          - final data bit, valid with rx_done
//               rx_done / rx_error   - frame ended cleanly / malformed
//               tx_req               - reply ready (level, held until tx_go)
//               tx_done              - encoder finished the reply
//               tx_go                - start modulation (1-cycle pulse)
//               busy                 - scheduler not idle
//               slot_idx             - slot of the last tx_go
//               dropped              - reply window closed (1-cycle pulse)
// Revision    : 1.0 - initial release
// ============================================================================
module fdt_tx_scheduler
    import fdt_pkg::*;
#(
    parameter int TIMING_ADJUST  = 6,
    parameter int CNT_WIDTH      = 12,
    parameter int MAX_LATE_SLOTS = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause_n_synchronised,
    input  logic       last_rx_bit,
    input  logic       rx_done,
    input  logic       rx_error,
    input  logic       tx_req,
    input  logic       tx_done,
    output logic       tx_go,
    output logic       busy,
    output logic [2:0] slot_idx,
    output logic       dropped
);

    fdt_state_t        r_state;
    fdt_state_t        w_next;
    logic              r_pause_d;
    logic              w_pause_rise;
    logic              w_pause_fall;
    logic              w_match;
    logic [SLOT_W-1:0] w_slot;
    logic              w_tx_go;
    logic              w_target_load;
    logic              w_slot_clear;
    logic              w_slot_inc;

    assign w_pause_rise = pause_n_synchronised & ~r_pause_d;
    assign w_pause_fall = ~pause_n_synchronised & r_pause_d;

    fdt_slot_counter #(
        .TIMING_ADJUST (TIMING_ADJUST),
        .CNT_WIDTH     (CNT_WIDTH)
    ) u_slot_counter (
        .clk         (clk),
        .rst         (rst),
        .cnt_clear   (w_pause_rise && (r_state != TX)),
        .cnt_hold    (r_state == TX),
        .target_load (w_target_load),
        .last_rx_bit (last_rx_bit),
        .slot_clear  (w_slot_clear),
        .slot_inc    (w_slot_inc),
        .match       (w_match),
        .slot        (w_slot)
    );

    // Pause line idles high, so resetting the delay tap high avoids a false rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pause_d <= 1'b1;
        end else begin
            r_state   <= w_next;
            r_pause_d <= pause_n_synchronised;
        end
    end

`ifdef FDT_LATE_SLOT_EN
    localparam logic [SLOT_W-1:0] c_max_slot = SLOT_W'(MAX_LATE_SLOTS);
`endif

    always_comb begin
        w_next        = r_state;
        w_tx_go       = 1'b0;
        w_target_load = 1'b0;
        w_slot_clear  = 1'b0;
        w_slot_inc    = 1'b0;
        case (r_state)
            IDLE: begin
                if (rx_done) begin
                    w_target_load = 1'b1;
                    w_slot_clear  = 1'b1;
                    w_next        = WAIT_FDT;
                end
            end
            WAIT_FDT: begin
                // A new PCD frame or a bad frame abandons the reply silently.
                if (w_pause_fall || rx_error) begin
                    w_next = IDLE;
                end else if (w_match) begin
                    if (tx_req) begin
                        w_tx_go = 1'b1;
                        w_next  = TX;
                    end else begin
`ifdef FDT_LATE_SLOT_EN
                        w_slot_inc = 1'b1;
                        w_next     = LATE;
`else
                        w_next     = DROP;
`endif
                    end
                end
            end
`ifdef FDT_LATE_SLOT_EN
            LATE: begin
                // The last allowed slot's window closes at the next grid
                // point, where the slot count has run past the limit.
                if (w_pause_fall) begin
                    w_next = IDLE;
                end else if (w_match) begin
                    if (w_slot > c_max_slot) begin
                        w_next = DROP;
                    end else if (tx_req) begin
                        w_tx_go = 1'b1;
                        w_next  = TX;
                    end else begin
                        w_slot_inc = 1'b1;
                    end
                end
            end
`endif
            TX: begin
                if (tx_done) begin
                    w_next = IDLE;
                end
            end
            DROP: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign tx_go   = w_tx_go & ~rst;
    assign busy    = (r_state != IDLE);
    assign dropped = (r_state == DROP);

`ifdef FDT_LATE_SLOT_EN
    logic [2:0] r_slot_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot_idx <= '0;
        end else if (w_tx_go) begin
            r_slot_idx <= w_slot[2:0];
        end
    end

    assign slot_idx = r_slot_idx;
`else
    // Only slot 0 exists without late slots.
    logic w_unused_slot;
    assign w_unused_slot = ^w_slot;
    assign slot_idx      = 3'd0;
`endif

endmodule
`default_nettype wire
